// File: rtl/spi_slave_sync_if.sv
// Pin and handshake bundle of the oversampled SPI slave.
// The slave modport is the design view; the master modport is the SPI master / control-logic view.
interface spi_slave_sync_if #(
  parameter int DATA_W = 16
);
  logic              SPI_SCK;
  logic              CHIP_SELECT;
  logic              MOSI;
  logic              MISO;
  logic              MISO_OE;
  logic [DATA_W-1:0] TX_DATA;
  logic              TX_VALID;
  logic              TX_READY;
  logic [DATA_W-1:0] RX_DATA;
  logic              RX_VALID;
  logic              TX_UNDERRUN;
  logic              FRAME_ERR;
  logic              BUSY;

  modport slave (
    input  SPI_SCK, CHIP_SELECT, MOSI, TX_DATA, TX_VALID,
    output MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, TX_UNDERRUN, FRAME_ERR, BUSY
  );

  modport master (
    output SPI_SCK, CHIP_SELECT, MOSI, TX_DATA, TX_VALID,
    input  MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, TX_UNDERRUN, FRAME_ERR, BUSY
  );
endinterface

// File: rtl/spi_slave_sync.sv
// SPI slave running entirely on CLK: SCK/CS/MOSI are synchronised and edge-detected,
// all four SPI modes, back-to-back words per CS frame, TX holding register with valid/ready.
//
//  state    | meaning
//  ---------+--------------------------------------------------------
//  S_IDLE   | CS high; SCK edges ignored, waiting for synced CS fall
//  S_ACTIVE | CS low; words shifted, counter tracks sampled bits
module spi_slave_sync #(
  parameter int DATA_W      = 16,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  spi_slave_sync_if.slave bus
);

  localparam int               CNT_W       = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(DATA_W - 1);
  localparam logic             SCK_IDLE    = (CPOL != 0);
  localparam bit               SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;
  logic                   sample_edge, shift_edge;

  logic [DATA_W-1:0] hold_data, tx_sh, tx_shifted, rx_sh, rx_next, rx_data_q;
  logic              hold_full, skip_shift, und_pend;
  logic [CNT_W-1:0]  bit_cnt;
  logic              rx_done_q, rx_valid_q, underrun_q, frame_err_q;

  logic do_sample, do_shift, word_done, word_start, b2b_start, frame_err, underrun_now;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= SCK_IDLE;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.SPI_SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.CHIP_SELECT};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s       = sck_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sck_rise    = sck_s & ~sck_d;
  assign sck_fall    = ~sck_s & sck_d;
  assign cs_fall     = ~cs_s & cs_d;
  assign cs_rise     = cs_s & ~cs_d;
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    word_start = 1'b0;
    b2b_start  = 1'b0;
    frame_err  = 1'b0;
    do_sample  = (state == S_ACTIVE) && sample_edge;
    do_shift   = (state == S_ACTIVE) && shift_edge;
    word_done  = do_sample && (bit_cnt == LAST_BIT);
    case (state)
      S_IDLE: begin
        if (cs_fall) begin
          state_nxt  = S_ACTIVE;
          word_start = 1'b1;
        end
      end
      S_ACTIVE: begin
        // A coincident sample is counted before the CS rise is judged.
        if (cs_rise) begin
          state_nxt = S_IDLE;
          frame_err = !word_done && (do_sample || (bit_cnt != '0));
        end else if (word_done) begin
          word_start = 1'b1;
          b2b_start  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rx_next    = (MSB_FIRST != 0) ? {rx_sh[DATA_W-2:0], mosi_s} : {mosi_s, rx_sh[DATA_W-1:1]};
  assign tx_shifted = (MSB_FIRST != 0) ? {tx_sh[DATA_W-2:0], 1'b0} : {1'b0, tx_sh[DATA_W-1:1]};

  // An empty holding register at a back-to-back word start is only reported once the master
  // actually clocks a bit of that word; a frame ending on a word boundary stays silent.
  assign underrun_now = (word_start && !b2b_start && !hold_full) ||
                        (und_pend && do_sample && (bit_cnt == '0));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold_data   <= '0;
      hold_full   <= 1'b0;
      tx_sh       <= '0;
      skip_shift  <= 1'b0;
      und_pend    <= 1'b0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (bus.TX_VALID && !hold_full) begin
        hold_data <= bus.TX_DATA;
        hold_full <= 1'b1;
      end else if (word_start) begin
        hold_full <= 1'b0;
      end

      // The shift edge right after a back-to-back start would drop the new first bit (CPHA=0);
      // for CPHA=1 the first shift edge of every word is consumed.
      if (word_start) begin
        tx_sh      <= hold_full ? hold_data : '0;
        skip_shift <= (CPHA != 0) || b2b_start;
      end else if (do_shift) begin
        if (skip_shift) skip_shift <= 1'b0;
        else            tx_sh      <= tx_shifted;
      end

      if (word_start)               und_pend <= b2b_start && !hold_full;
      else if (do_sample || cs_rise) und_pend <= 1'b0;

      if (do_sample) begin
        rx_sh   <= rx_next;
        bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
      end
      if ((word_start && !b2b_start) || (state == S_ACTIVE && cs_rise)) bit_cnt <= '0;

      if (word_done) rx_data_q <= rx_next;
      rx_done_q   <= word_done;
      rx_valid_q  <= rx_done_q;
      underrun_q  <= underrun_now;
      frame_err_q <= frame_err;
    end
  end

  assign bus.MISO        = (MSB_FIRST != 0) ? tx_sh[DATA_W-1] : tx_sh[0];
  assign bus.MISO_OE     = ~cs_s;
  assign bus.TX_READY    = ~hold_full;
  assign bus.RX_DATA     = rx_data_q;
  assign bus.RX_VALID    = rx_valid_q;
  assign bus.TX_UNDERRUN = underrun_q;
  assign bus.FRAME_ERR   = frame_err_q;
  assign bus.BUSY        = (state == S_ACTIVE);

endmodule
